// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the register-file write-port arbiter
package wb_arb_pkg;

  localparam int DEF_MQ_DEPTH   = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } mq_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - circular FIFO of multiplier results with occupancy count
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEF_MQ_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  mq_entry_t     push_data,
  input  logic          pop,
  output mq_entry_t     head,
  output logic [CW-1:0] count
);

  mq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - WB/multiplier write-port arbiter with pending-register scoreboard
// Optional same-cycle multiplier bypass: WB_MUL_BYPASS_EN
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MQ_DEPTH   = DEF_MQ_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_wr_i,
  input  logic [4:0]                pipe_waddr_i,
  input  logic [31:0]               pipe_wdata_i,
  input  logic                      mul_valid_i,
  output logic                      mul_ready_o,
  input  logic [4:0]                mul_waddr_i,
  input  logic [31:0]               mul_wdata_i,
  input  logic                      issue_valid_i,
  input  logic [4:0]                issue_waddr_i,
  input  logic [4:0]                chk_raddr1_i,
  input  logic [4:0]                chk_raddr2_i,
  input  logic [4:0]                chk_waddr_i,
  output logic                      hazard_o,
  output logic                      wb_stall_o,
  output logic                      reg_wr_o,
  output logic [4:0]                waddr_o,
  output logic [31:0]               wdata_o,
  output logic [31:0]               pending_o,
  output logic [$clog2(MQ_DEPTH):0] mq_count_o
);

  localparam int CW = $clog2(MQ_DEPTH) + 1;

  mq_entry_t      head;
  mq_entry_t      push_data;
  logic [CW-1:0]  count;
  logic           q_empty;
  logic           port_free;
  logic           pop;
  logic           push;
  logic           bypass;
  logic [3:0]     starve_cnt;
  logic [3:0]     starve_nxt;
  logic           stall_q;
  logic [31:0]    pending_q;
  logic [31:0]    pending_nxt;

  assign q_empty     = (count == '0);
  assign mul_ready_o = (count != CW'(MQ_DEPTH));
  assign port_free   = !pipe_wr_i || (pipe_waddr_i == 5'd0) || stall_q;
  assign pop         = !q_empty && port_free;

`ifdef WB_MUL_BYPASS_EN
  assign bypass = mul_valid_i && q_empty && port_free;
`else
  assign bypass = 1'b0;
`endif

  assign push      = mul_valid_i && mul_ready_o && !bypass;
  assign push_data = '{waddr: mul_waddr_i, wdata: mul_wdata_i};

  wb_result_fifo #(.DEPTH(MQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Queue head beats WB whenever WB leaves the port free; x0 targets never write
  always_comb begin
    reg_wr_o = 1'b0;
    waddr_o  = 5'd0;
    wdata_o  = 32'd0;
    if (!rst) begin
      reg_wr_o = 1'b0;
    end else if (pop) begin
      reg_wr_o = (head.waddr != 5'd0);
      waddr_o  = head.waddr;
      wdata_o  = head.wdata;
    end else if (bypass) begin
      reg_wr_o = (mul_waddr_i != 5'd0);
      waddr_o  = mul_waddr_i;
      wdata_o  = mul_wdata_i;
    end else if (pipe_wr_i && pipe_waddr_i != 5'd0 && !stall_q) begin
      reg_wr_o = 1'b1;
      waddr_o  = pipe_waddr_i;
      wdata_o  = pipe_wdata_i;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (q_empty || pop)
      starve_nxt = 4'd0;
    else if (starve_cnt != 4'(STARVE_MAX))
      starve_nxt = starve_cnt + 4'd1;
  end

  // Clear first, then set, so an issue to the register being retired wins
  always_comb begin
    pending_nxt = pending_q;
    if (pop)
      pending_nxt[head.waddr] = 1'b0;
    if (bypass)
      pending_nxt[mul_waddr_i] = 1'b0;
    if (issue_valid_i && issue_waddr_i != 5'd0)
      pending_nxt[issue_waddr_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
      pending_q  <= 32'd0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_q    <= (starve_nxt == 4'(STARVE_MAX));
      pending_q  <= pending_nxt;
    end
  end

  assign hazard_o   = (chk_raddr1_i != 5'd0 && pending_q[chk_raddr1_i]) ||
                      (chk_raddr2_i != 5'd0 && pending_q[chk_raddr2_i]) ||
                      (chk_waddr_i  != 5'd0 && pending_q[chk_waddr_i]);
  assign wb_stall_o = stall_q;
  assign pending_o  = pending_q;
  assign mq_count_o = count;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-register scoreboard for the single register-file write port in the RV32IM 5-stage pipeline. It merges in-order writeback from the pipeline WB stage with out-of-band results from the iterative multiplier. Multiplier results are buffered in a small queue and tracked per destination register, so decode can stall on RAW/WAW hazards. Sits between WB/multiplier and the register file's `reg_wrW`/`waddr`/`wdata` port.

## Interface
- `MQ_DEPTH`, 2: multiplier result queue depth; power of two, 2..8.
- `STARVE_MAX`, 4: cycles a queued result may wait before WB is forced to yield; 1..15.
- `clk  input  1`: single clock; all state on posedge.
- `rst  input  1`: asynchronous, active-low reset.
- `pipe_wr_i  input  1`: WB stage write enable.
- `pipe_waddr_i  input  5`: WB destination register.
- `pipe_wdata_i  input  32`: WB data.
- `mul_valid_i  input  1`: multiplier result valid.
- `mul_ready_o  output  1`: queue can accept.
- `mul_waddr_i  input  5`: multiplier destination register.
- `mul_wdata_i  input  32`: multiplier result.
- `issue_valid_i  input  1`: M-instruction issued to multiplier this cycle.
- `issue_waddr_i  input  5`: its destination register.
- `chk_raddr1_i`, `chk_raddr2_i`, `chk_waddr_i  input  5 each`: decode-stage operands and destination.
- `hazard_o  output  1`: any nonzero `chk_*` register is pending.
- `wb_stall_o  output  1`: WB must hold its instruction this cycle.
- `reg_wr_o  output  1`: register-file write enable.
- `waddr_o  output  5`: register-file write address.
- `wdata_o  output  32`: register-file write data.
- `pending_o  output  32`: scoreboard bit vector; bit 0 is always 0.
- `mq_count_o  output  $clog2(MQ_DEPTH)+1`: queue occupancy.

## Operation
- Queue
  - Circular FIFO with read and write pointers and a count.
  - A push occurs when `mul_valid_i && mul_ready_o`.
  - `mul_ready_o = (count != MQ_DEPTH)`.
- Port free condition: the port is free when `!pipe_wr_i || pipe_waddr_i == 0 || wb_stall_o`.
- Grant, evaluated combinationally each cycle:
  - If the queue is non-empty and the port is free, the queue head is written and popped.
  - Otherwise the WB write passes through, but only when `pipe_wr_i` is set and `pipe_waddr_i` is nonzero.
  - Writes to x0 never assert `reg_wr_o`.
  - A queued entry addressed to x0 is popped with `reg_wr_o = 0`.
- Starvation counter
  - Increments while the queue is non-empty and the head is not popped.
  - Clears on any pop, and clears when the queue is empty.
  - `wb_stall_o` is a register that is set on the cycle after the counter reaches `STARVE_MAX`, and cleared after one cycle.
  - While `wb_stall_o` is high, the WB write is ignored and the pipeline must re-present the same instruction next cycle.
- Scoreboard
  - Setting a bit: `issue_valid_i` with nonzero `issue_waddr_i` sets `pending[issue_waddr_i]`.
  - Clearing a bit: a queue pop clears `pending[head.waddr]`.
  - Same register set and cleared in one cycle: set wins.
  - Issuing to an already-pending register is illegal; decode prevents it via `hazard_o` on `chk_waddr_i`. The bench asserts this never happens.
- `hazard_o` is the OR over the three `chk_*` addresses of their pending bits, with x0 excluded.
- Push and pop in the same cycle leave the count unchanged. A push while full is impossible by handshake.

## Timing
- Reset (`rst` low, asynchronous):
  - Queue empty, pointers 0, count 0.
  - `pending_o = 0`, starvation counter 0, `wb_stall_o = 0`.
  - `reg_wr_o`, `waddr_o`, `wdata_o` forced to 0.
  - `mul_ready_o = 1`, `hazard_o = 0`.
- Reset mid-operation discards queued results and all pending bits immediately.
- Multiplier latency: a result pushed at posedge N is at the queue head in cycle N+1. It is written that cycle at the earliest.
- The register file samples the write outputs on negedge. All write outputs are combinational from registered queue state and the `pipe_*` inputs.
- `hazard_o` is combinational, so a pending bit set at posedge N is visible to decode in cycle N+1.
- Worst-case wait for a queued head is `STARVE_MAX` + 1 cycles.

## Configuration
- `WB_MUL_BYPASS_EN` defined:
  - A result with `mul_valid_i` high, an empty queue and a free port is written to the register file in the same cycle, without entering the queue.
  - Its pending bit clears at that edge.
- Not defined: every multiplier result passes through the queue, giving a minimum latency of 1 cycle.

## Structure
- A shared package `wb_arb_pkg` holds:
  - the `mq_entry_t` struct {`waddr[4:0]`, `wdata[31:0]`};
  - the default `MQ_DEPTH` and `STARVE_MAX` localparams.
- One sub-module, `wb_result_fifo`: a parameterised FIFO of `mq_entry_t` with push/pop/count. The arbiter and scoreboard logic live in the top module.

## Test plan
- Reset with a result queued → after `rst` is released: `mq_count_o = 0`, `pending_o = 0`, `mul_ready_o = 1`, `reg_wr_o = 0`.
- `issue_valid_i` with `issue_waddr_i = 5` → `pending_o[5] = 1` next cycle. `chk_raddr1_i = 5` → `hazard_o = 1`. Multiplier pushes (x5, 0x0000_0006) while WB is idle → `reg_wr_o = 1`, `waddr_o = 5`, `wdata_o = 6` one cycle later, then `pending_o[5] = 0`.
- WB writes every cycle to x1 with the queue holding one entry and `STARVE_MAX = 4` → `wb_stall_o` rises after the 4th blocked cycle. The queue head is written in the stall cycle, and the WB x1 write lands the following cycle.
- Fill the queue (2 pushes, WB busy) → `mul_ready_o = 0`. A third `mul_valid_i` is held. After one pop, `mul_ready_o = 1`.
- Queue entry addressed to x0, and a WB write to x0 → `reg_wr_o` stays 0 in both cases, and the entry still pops.
- With `WB_MUL_BYPASS_EN`, empty queue, WB idle: push (x7, 0x1234) → written in the same cycle and `mq_count_o` stays 0. Without the macro → written 1 cycle later.
